// File: rtl/ysyx_22041071_ifu_fetch.sv
// Instruction fetch unit: issues single-beat AXI reads for the current PC,
// presents the returned instruction to decode, and handles control-flow
// redirects at any point of a fetch without breaking AXI handshakes.
//
// state  | meaning
// S_AR   | request for pc on the AR channel, waiting for ar_ready
// S_R    | request accepted, waiting for the last R beat
// S_HOLD | instruction presented to decode, waiting for inst_ready
module ysyx_22041071_ifu_fetch #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32,
  parameter int LEN_W  = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [LEN_W-1:0]  ar_len,
  output logic [2:0]        ar_size,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_W / 8);

  typedef enum logic [1:0] {S_AR, S_R, S_HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              drop;
  logic [DATA_W-1:0] r_shift;
  logic [INST_W-1:0] lane;

  assign ar_addr = pc;
  assign ar_len  = '0;
  assign ar_size = 3'($clog2(INST_W / 8));

  // On a 64-bit bus the word at PC sits in the upper half when PC[2] is set.
  assign r_shift = (DATA_W > 32 && pc[2]) ? (r_data >> 32) : r_data;
  assign lane    = INST_W'(r_shift);

  // Fetch sequencer; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_AR;
      pc         <= START_ADDR;
      pend_pc    <= '0;
      drop       <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= 1'b0;
      ar_valid   <= 1'b1;
      r_ready    <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          // pc (and so ar_addr) is frozen here; a redirect only arms the drop.
          if (redirect_valid) begin
            drop    <= 1'b1;
            pend_pc <= redirect_pc;
          end
          if (ar_ready) begin
            state    <= S_R;
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        S_R: begin
          if (r_valid && r_last) begin
            r_ready <= 1'b0;
            if (drop || redirect_valid) begin
              // Stale data: restart from the newest redirect target.
              pc       <= redirect_valid ? redirect_pc : pend_pc;
              drop     <= 1'b0;
              state    <= S_AR;
              ar_valid <= 1'b1;
            end else begin
              inst       <= lane;
              inst_pc    <= pc;
              inst_err   <= |r_resp;
              state      <= S_HOLD;
              inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            drop    <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) begin
            pc         <= redirect_valid ? redirect_pc : pc + STEP;
            state      <= S_AR;
            inst_valid <= 1'b0;
            ar_valid   <= 1'b1;
          end
        end
        default: begin
          state      <= S_AR;
          ar_valid   <= 1'b1;
          r_ready    <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_ifu_fetch.sv
// Self-checking bench for the fetch unit: directed cycle table, hand-written
// redirect/reset corner sequences, and a randomized run against a PC-stream model.
module tb_ysyx_22041071_ifu_fetch;

  localparam logic [63:0] S  = 64'h8000_0000;
  localparam logic [63:0] D0 = 64'h0000_0013_0000_0093;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_err;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22041071_ifu_fetch dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    redirect_valid = 1'b0; redirect_pc = '0; ar_ready = 1'b0;
    r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0; inst_ready = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Memory image: instruction word at a 4-byte address, error response per 8-byte line.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return (lo * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [1:0] resp_at(input logic [63:0] a);
    if (a[7:3] == 5'd9)  return 2'b10;
    if (a[7:3] == 5'd17) return 2'b11;
    return 2'b00;
  endfunction

  typedef struct packed {
    logic        ar_ready, r_valid, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        inst_ready, redir;
    logic [63:0] redir_pc;
    logic        e_arv;
    logic [63:0] e_addr;
    logic        e_rr, e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t tab[14];

  logic [191:0] act_v, exp_v;

  // Random-phase bookkeeping.
  logic        rd_pending;
  logic [63:0] rd_addr, rd_line, exp_pc, prev_ar_addr, prev_pc;
  int          rd_delay, rd_beats, accepted;
  logic        prev_ar_stall, prev_hold;
  logic [31:0] prev_inst;
  logic        prev_err;

  initial begin
    reset = 1'b1;
    idle_inputs();

    // outputs checked at the falling edge, then inputs driven for the next rising edge
    tab[0]  = '{1'b1,1'b0,1'b0,64'd0,2'b00,1'b0,1'b0,64'd0, 1'b1,S,1'b0,1'b0,32'd0,64'd0,1'b0};
    tab[1]  = '{1'b0,1'b1,1'b1,D0,2'b00,1'b0,1'b0,64'd0, 1'b0,64'd0,1'b1,1'b0,32'd0,64'd0,1'b0};
    tab[2]  = '{1'b0,1'b0,1'b0,64'd0,2'b00,1'b0,1'b0,64'd0, 1'b0,64'd0,1'b0,1'b1,32'h0000_0093,S,1'b0};
    tab[3]  = '{1'b0,1'b0,1'b0,64'd0,2'b00,1'b1,1'b0,64'd0, 1'b0,64'd0,1'b0,1'b1,32'h0000_0093,S,1'b0};
    tab[4]  = '{1'b1,1'b0,1'b0,64'd0,2'b00,1'b0,1'b0,64'd0, 1'b1,S+64'd4,1'b0,1'b0,32'd0,64'd0,1'b0};
    tab[5]  = '{1'b0,1'b1,1'b1,D0,2'b00,1'b0,1'b0,64'd0, 1'b0,64'd0,1'b1,1'b0,32'd0,64'd0,1'b0};
    tab[6]  = '{1'b0,1'b0,1'b0,64'd0,2'b00,1'b1,1'b0,64'd0, 1'b0,64'd0,1'b0,1'b1,32'h0000_0013,S+64'd4,1'b0};
    tab[7]  = '{1'b1,1'b0,1'b0,64'd0,2'b00,1'b0,1'b0,64'd0, 1'b1,S+64'd8,1'b0,1'b0,32'd0,64'd0,1'b0};
    tab[8]  = '{1'b0,1'b1,1'b0,64'hFFFF_FFFF_FFFF_FFFF,2'b11,1'b0,1'b0,64'd0, 1'b0,64'd0,1'b1,1'b0,32'd0,64'd0,1'b0};
    tab[9]  = '{1'b0,1'b1,1'b1,64'hDEAD_BEEF_1234_5678,2'b10,1'b0,1'b0,64'd0, 1'b0,64'd0,1'b1,1'b0,32'd0,64'd0,1'b0};
    tab[10] = '{1'b0,1'b0,1'b0,64'd0,2'b00,1'b0,1'b1,S+64'h300, 1'b0,64'd0,1'b0,1'b1,32'h1234_5678,S+64'd8,1'b1};
    tab[11] = '{1'b0,1'b1,1'b1,64'h1111_2222_3333_4444,2'b00,1'b0,1'b0,64'd0, 1'b1,S+64'h300,1'b0,1'b0,32'd0,64'd0,1'b0};
    tab[12] = '{1'b1,1'b0,1'b0,64'd0,2'b00,1'b0,1'b0,64'd0, 1'b1,S+64'h300,1'b0,1'b0,32'd0,64'd0,1'b0};
    tab[13] = '{1'b0,1'b0,1'b0,64'd0,2'b00,1'b0,1'b0,64'd0, 1'b0,64'd0,1'b1,1'b0,32'd0,64'd0,1'b0};

    // Reset state
    do_reset();
    chk("reset_handshakes", {189'd0, ar_valid, r_ready, inst_valid}, {189'd0, 3'b100});
    chk("reset_ar_addr", ar_addr, S);
    chk("reset_ar_len_size", {ar_len, ar_size}, {8'd0, 3'b010});
    chk("reset_inst_regs", {inst, inst_pc, inst_err}, 97'd0);

    // Directed cycle table
    for (int i = 0; i < 14; i++) begin
      act_v = {ar_valid, ar_valid ? ar_addr : 64'd0, r_ready, inst_valid,
               inst_valid ? inst : 32'd0, inst_valid ? inst_pc : 64'd0,
               inst_valid ? inst_err : 1'b0};
      exp_v = {tab[i].e_arv, tab[i].e_addr, tab[i].e_rr, tab[i].e_iv,
               tab[i].e_inst, tab[i].e_pc, tab[i].e_err};
      chk($sformatf("table_row%0d", i), act_v, exp_v);
      ar_ready = tab[i].ar_ready; r_valid = tab[i].r_valid; r_last = tab[i].r_last;
      r_data = tab[i].r_data; r_resp = tab[i].r_resp; inst_ready = tab[i].inst_ready;
      redirect_valid = tab[i].redir; redirect_pc = tab[i].redir_pc;
      @(negedge clk);
    end
    idle_inputs();

    // AR stalled five cycles with a redirect in the middle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ar_stall_cycle%0d", k), {ar_valid, ar_addr}, {1'b1, S});
      redirect_valid = (k == 2);
      redirect_pc = S + 64'h100;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    chk("ar_stall_release", {ar_valid, ar_addr}, {1'b1, S});
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid = 1'b1; r_last = 1'b1; r_data = D0;
    @(negedge clk);
    r_valid = 1'b0; r_last = 1'b0;
    chk("ar_stall_drop", {inst_valid, ar_valid, ar_addr}, {1'b0, 1'b1, S + 64'h100});

    // Two redirects while waiting for data: only the latest survives
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("two_redir_in_r", r_ready, 1'b1);
    redirect_valid = 1'b1; redirect_pc = S + 64'h40;
    @(negedge clk);
    redirect_pc = S + 64'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    r_valid = 1'b1; r_last = 1'b1; r_data = D0;
    @(negedge clk);
    r_valid = 1'b0; r_last = 1'b0;
    chk("two_redir_result", {inst_valid, ar_valid, ar_addr}, {1'b0, 1'b1, S + 64'h80});

    // Reset in the middle of a read, with a last beat on the bus
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("reset_mid_in_r", r_ready, 1'b1);
    reset = 1'b1; r_valid = 1'b1; r_last = 1'b1; r_data = D0;
    @(negedge clk);
    reset = 1'b0; r_valid = 1'b0; r_last = 1'b0;
    chk("reset_mid_result", {ar_valid, ar_addr, r_ready, inst_valid}, {1'b1, S, 1'b0, 1'b0});

    // PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; ar_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b1; r_last = 1'b1; r_data = D0;
    @(negedge clk);
    r_valid = 1'b0; r_last = 1'b0;
    chk("wrap_redirect_addr", {ar_valid, ar_addr}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid = 1'b1; r_last = 1'b1; r_data = 64'h0000_0073_FFFF_FFFF;
    @(negedge clk);
    r_valid = 1'b0; r_last = 1'b0;
    chk("wrap_upper_lane", {inst_valid, inst, inst_pc}, {1'b1, 32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC});
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("wrap_next_addr", {ar_valid, ar_addr}, {1'b1, 64'd0});

    // Randomized run: every accepted instruction must follow the PC stream
    do_reset();
    exp_pc = S; rd_pending = 1'b0; rd_addr = '0; rd_delay = 0; rd_beats = 0;
    accepted = 0; prev_ar_stall = 1'b0; prev_hold = 1'b0;
    prev_ar_addr = '0; prev_pc = '0; prev_inst = '0; prev_err = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      chk("rnd_r_ready", r_ready, rd_pending);
      chk("rnd_one_state", $countones({ar_valid, r_ready, inst_valid}), 1);
      if (prev_ar_stall)
        chk("rnd_ar_stable", {ar_valid, ar_addr}, {1'b1, prev_ar_addr});
      if (prev_hold)
        chk("rnd_hold_stable", {inst_valid, inst, inst_pc, inst_err},
            {1'b1, prev_inst, prev_pc, prev_err});

      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = S + 64'(4 * $urandom_range(0, 63));
      ar_ready = ($urandom_range(0, 2) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      if (rd_pending) begin
        if (rd_delay > 0) begin
          rd_delay--;
          r_valid = 1'b0; r_last = 1'b0;
        end else begin
          rd_line = {rd_addr[63:3], 3'b000};
          r_valid = 1'b1;
          r_last = (rd_beats == 1);
          r_data = r_last ? {word_at(rd_line + 64'd4), word_at(rd_line)}
                          : {$urandom, $urandom};
          r_resp = r_last ? resp_at(rd_line) : 2'($urandom_range(0, 3));
        end
      end else begin
        r_valid = ($urandom_range(0, 3) == 0);
        r_last = 1'($urandom_range(0, 1));
        r_data = {$urandom, $urandom};
        r_resp = 2'($urandom_range(0, 3));
      end

      if (rd_pending && r_valid && r_ready) begin
        if (r_last) rd_pending = 1'b0;
        else rd_beats--;
      end
      if (ar_valid && ar_ready) begin
        rd_pending = 1'b1;
        rd_addr = ar_addr;
        rd_delay = $urandom_range(0, 2);
        rd_beats = $urandom_range(1, 2);
      end
      if (inst_valid && inst_ready) begin
        accepted++;
        chk("rnd_inst_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, word_at(exp_pc));
        chk("rnd_inst_err", inst_err, resp_at(exp_pc) != 2'b00);
        exp_pc = exp_pc + 64'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc;

      prev_ar_stall = ar_valid && !ar_ready;
      prev_ar_addr = ar_addr;
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      prev_inst = inst; prev_pc = inst_pc; prev_err = inst_err;
    end
    chk("rnd_progress", accepted >= 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_ifu_fetch.md
YSYX_22041071_IFU_FETCH -- requirements
Module: ysyx_22041071_ifu_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, PC and AXI address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, AXI read data width (32 or 64).
REQ-003 The block SHALL have parameter INST_W, default 32, instruction width.
REQ-004 The block SHALL have parameter LEN_W, default 8, AXI burst length field width.
REQ-005 The block SHALL have parameter START_ADDR, default 64'h8000_0000, PC value after reset.
REQ-006 Ports SHALL be, clock and reset first:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  control-flow redirect request (branch/jal/jalr/trap, already arbitrated)
- redirect_pc  in  ADDR_W  redirect target
- ar_valid  out  1  AXI AR valid
- ar_ready  in  1  AXI AR ready
- ar_addr  out  ADDR_W  fetch address
- ar_len  out  LEN_W  burst length
- ar_size  out  3  beat size
- r_valid  in  1  AXI R valid
- r_ready  out  1  AXI R ready
- r_data  in  DATA_W  read data
- r_resp  in  2  read response
- r_last  in  1  last beat
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst  out  INST_W  fetched instruction
- inst_pc  out  ADDR_W  PC of inst
- inst_err  out  1  bus error on this fetch (r_resp != 0)

Function
REQ-007 The block SHALL implement states S_AR (issue request), S_R (await data), S_HOLD (present instruction); one request outstanding at most.
REQ-008 ar_valid SHALL be 1 exactly in S_AR; r_ready exactly in S_R; inst_valid exactly in S_HOLD.
REQ-009 ar_addr SHALL equal the fetch PC register; ar_len SHALL be 0; ar_size SHALL be log2(INST_W/8) (3'b010 for 32).
REQ-010 Once ar_valid is 1, ar_addr SHALL stay constant until the cycle ar_valid&ar_ready (AXI stability), regardless of redirect.
REQ-011 S_AR, ar_valid&ar_ready SHALL move to S_R next cycle.
REQ-012 S_R, r_valid&r_ready&r_last with drop flag clear SHALL capture inst, inst_pc=PC, inst_err=(r_resp!=0) and move to S_HOLD; beats without r_last SHALL be accepted and ignored.
REQ-013 With DATA_W=64, inst SHALL be r_data[63:32] when PC[2]=1, else r_data[31:0]; with DATA_W=32, r_data[31:0].
REQ-014 S_HOLD, inst/inst_pc/inst_err SHALL stay stable until inst_valid&inst_ready; then PC<=PC+INST_W/8 (mod 2^ADDR_W, wrap allowed) and move to S_AR.
REQ-015 Minimum latency SHALL be: AR handshake cycle N, R last beat cycle N+k, inst_valid cycle N+k+1; back-to-back fetch throughput one instruction per 3 cycles with zero-wait slave.
REQ-016 Redirect in S_HOLD: held instruction SHALL be discarded (inst_valid 0 next cycle), PC<=redirect_pc, move to S_AR.
REQ-017 Redirect in S_HOLD same cycle as inst_ready: handshake SHALL count as consumed, next PC SHALL be redirect_pc (not PC+4).
REQ-018 Redirect in S_AR (with or without ar_ready) or S_R: SHALL set drop flag and store redirect_pc as pending PC; request completes normally on the bus.
REQ-019 S_R last beat with drop flag set (or redirect_valid in the same cycle) SHALL discard data, load PC from the latest redirect target, clear drop, move to S_AR; no inst_valid.
REQ-020 Multiple redirects before the drop completes SHALL keep only the most recent redirect_pc.
REQ-021 r_valid outside S_R SHALL be ignored (r_ready 0); no state change.

Reset
REQ-022 reset SHALL take priority over every input in the same cycle, including mid-transaction.
REQ-023 On reset: state S_AR, PC=START_ADDR, drop flag 0, pending PC 0, inst/inst_pc 0, inst_err 0; first cycle after reset ar_valid=1, ar_addr=START_ADDR, r_ready=0, inst_valid=0.

Verification
REQ-024 Reset, ar_ready=1, r_valid+r_last one cycle later with r_data=64'h0000_0013_0000_0093 -> inst=32'h0000_0093, inst_pc=0x8000_0000; after inst_ready, ar_addr=0x8000_0004, next inst=32'h0000_0013.
REQ-025 ar_ready held 0 for 5 cycles while redirect_pc=0x8000_0100 pulses in cycle 2 -> ar_addr stays 0x8000_0000 all 5 cycles; returned data dropped; next ar_addr=0x8000_0100.
REQ-026 Instruction held with inst_ready=0 for 4 cycles -> inst, inst_pc constant; redirect 0x8000_0200 together with inst_ready -> next ar_addr=0x8000_0200.
REQ-027 Two redirects (0x8000_0040 then 0x8000_0080) during S_R -> first returned data dropped, next ar_addr=0x8000_0080.
REQ-028 r_resp=2'b10 on last beat -> inst_valid=1 with inst_err=1; reset asserted in S_R -> next cycle ar_valid=1, ar_addr=START_ADDR, r_ready=0.
